// File: rtl/range_merger_8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : range_merger_8_pkg
// Description : Shared pair type, widths and merge-state encoding for
//               range_merger_8 and batch_fifo. Also provides the aoc5
//               flat-array macros.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef ARR_8_FLAT_WIDTH
`define ARR_8_FLAT_WIDTH 256
`endif

`ifndef INDEX_FLAT
`define INDEX_FLAT(i) ((i)*32) +: 32
`endif

package range_merger_8_pkg;

    localparam int VAL_WIDTH = 16;

    typedef struct packed {
        logic [VAL_WIDTH-1:0] start_val;
        logic [VAL_WIDTH-1:0] end_val;
    } tuple_pair_t;

    localparam int c_pair_width       = $bits(tuple_pair_t);
    localparam int c_arr_8_flat_width = 8 * c_pair_width;

    typedef enum logic [1:0] {
        MERGE_IDLE  = 2'd0,
        MERGE_ACC   = 2'd1,
        MERGE_DRAIN = 2'd2,
        MERGE_DONE  = 2'd3
    } merge_state_t;

endpackage

`default_nettype wire

// File: rtl/range_merger_8_fifo.sv
`default_nettype none
// ============================================================================
// Module      : batch_fifo
// Description : Register-based FIFO holding whole 8-pair batches; read data
//               is the head entry, visible the cycle after it is written.
// Revision    : 1.0 - initial release
// ============================================================================

module batch_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_full    = (r_count == (c_aw+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_do_wr = i_wr_en && !o_full;
    assign w_do_rd = i_rd_en && !o_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/range_merger_8.sv
`default_nettype none
// ============================================================================
// Module      : range_merger_8
// Description : Buffers sorted 8-pair batches and merges overlapping or
//               adjacent {start,end} ranges into a ready/valid output stream.
//               Optional AOC5_RANGE_SUM_EN adds sum_out (total covered length).
// Revision    : 1.0 - initial release
// ============================================================================

module range_merger_8
    import range_merger_8_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int IN_FLIGHT  = 6
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          valid_in,
    input  logic [c_arr_8_flat_width-1:0] pairs_in_flat,
    input  logic                          flush_in,
    output logic                          almost_full_out,
    output logic                          overflow_out,
    output logic                          range_valid_out,
    input  logic                          range_ready_in,
    output logic [c_pair_width-1:0]       range_out,
`ifdef AOC5_RANGE_SUM_EN
    output logic [VAL_WIDTH+7:0]          sum_out,
`endif
    output logic                          done_out
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_af_level = c_cnt_w'(FIFO_DEPTH - IN_FLIGHT);

    logic [c_arr_8_flat_width-1:0] w_fifo_data;
    logic                          w_fifo_full;
    logic                          w_fifo_empty;
    logic [c_cnt_w-1:0]            w_fifo_count;
    logic                          w_wr_req;
    logic                          w_pop;

    tuple_pair_t [7:0]             w_head;
    tuple_pair_t                   w_pair;
    logic                          w_pad;
    logic                          w_merge;
    logic                          w_out_free;
    logic [VAL_WIDTH:0]            w_cur_end_p1;

    merge_state_t                  r_state;
    merge_state_t                  w_state_next;
    tuple_pair_t                   r_cur;
    tuple_pair_t                   w_cur_next;
    logic [2:0]                    r_idx;
    logic                          w_consume;
    logic                          w_load_out;
    logic                          r_flush_seen;
    logic                          r_overflow;
    logic                          r_out_valid;
    tuple_pair_t                   r_out_data;

    // Batches arriving after the end-of-data pulse are silently ignored.
    assign w_wr_req = valid_in && !r_flush_seen;
    assign w_pop    = w_consume && (r_idx == 3'd7);

    batch_fifo #(
        .WIDTH (c_arr_8_flat_width),
        .DEPTH (FIFO_DEPTH)
    ) u_batch_fifo (
        .clock     (clock),
        .reset     (reset),
        .i_wr_en   (w_wr_req),
        .i_wr_data (pairs_in_flat),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    assign w_head       = w_fifo_data;
    assign w_pair       = w_head[r_idx];
    assign w_pad        = (w_pair.start_val == '0) && (w_pair.end_val == '0);
    assign w_cur_end_p1 = {1'b0, r_cur.end_val} + {{VAL_WIDTH{1'b0}}, 1'b1};
    assign w_merge      = ({1'b0, w_pair.start_val} <= w_cur_end_p1);
    assign w_out_free   = !r_out_valid || range_ready_in;

    always_comb begin
        w_state_next = r_state;
        w_cur_next   = r_cur;
        w_consume    = 1'b0;
        w_load_out   = 1'b0;
        case (r_state)
            MERGE_IDLE: begin
                if (!w_fifo_empty) begin
                    w_consume = 1'b1;
                    if (!w_pad) begin
                        w_cur_next   = w_pair;
                        w_state_next = MERGE_ACC;
                    end
                end else if (r_flush_seen) begin
                    w_state_next = MERGE_DONE;
                end
            end
            MERGE_ACC: begin
                if (!w_fifo_empty) begin
                    if (w_pad) begin
                        w_consume = 1'b1;
                    end else if (w_merge) begin
                        w_consume = 1'b1;
                        if (w_pair.end_val > r_cur.end_val) w_cur_next.end_val = w_pair.end_val;
                    end else if (w_out_free) begin
                        w_consume  = 1'b1;
                        w_load_out = 1'b1;
                        w_cur_next = w_pair;
                    end
                end else if (r_flush_seen) begin
                    w_state_next = MERGE_DRAIN;
                end
            end
            MERGE_DRAIN: begin
                if (w_out_free) begin
                    w_load_out   = 1'b1;
                    w_state_next = MERGE_DONE;
                end
            end
            MERGE_DONE: begin
                w_state_next = MERGE_DONE;
            end
            default: begin
                w_state_next = MERGE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= MERGE_IDLE;
            r_cur        <= '0;
            r_idx        <= '0;
            r_flush_seen <= 1'b0;
            r_overflow   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cur   <= w_cur_next;
            if (w_consume) r_idx <= r_idx + 3'd1;
            if (flush_in) r_flush_seen <= 1'b1;
            if (w_wr_req && w_fifo_full) r_overflow <= 1'b1;
            // A load takes priority: the old value is being accepted this cycle.
            if (w_load_out) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_cur;
            end else if (range_ready_in) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign almost_full_out = (w_fifo_count >= c_af_level);
    assign overflow_out    = r_overflow;
    assign range_valid_out = r_out_valid;
    assign range_out       = r_out_data;
    assign done_out        = (r_state == MERGE_DONE) && !r_out_valid;

`ifdef AOC5_RANGE_SUM_EN
    logic [VAL_WIDTH+7:0] r_sum;
    logic [VAL_WIDTH+7:0] w_len;

    assign w_len = {8'd0, r_cur.end_val - r_cur.start_val} + {{(VAL_WIDTH+7){1'b0}}, 1'b1};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sum <= '0;
        end else if (w_load_out) begin
            r_sum <= r_sum + w_len;
        end
    end

    assign sum_out = r_sum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_range_merger_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_range_merger_8
// Description : Directed self-checking bench for range_merger_8.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_range_merger_8;
    import range_merger_8_pkg::*;

    logic                          clock = 1'b0;
    logic                          reset = 1'b1;
    logic                          valid_in = 1'b0;
    logic [c_arr_8_flat_width-1:0] pairs_in_flat = '0;
    logic                          flush_in = 1'b0;
    logic                          almost_full_out;
    logic                          overflow_out;
    logic                          range_valid_out;
    logic                          range_ready_in = 1'b1;
    logic [c_pair_width-1:0]       range_out;
    logic                          done_out;
`ifdef AOC5_RANGE_SUM_EN
    logic [VAL_WIDTH+7:0]          sum_out;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];
    tuple_pair_t [7:0] bt;

    range_merger_8 #(.FIFO_DEPTH(8), .IN_FLIGHT(6)) dut (
        .clock           (clock),
        .reset           (reset),
        .valid_in        (valid_in),
        .pairs_in_flat   (pairs_in_flat),
        .flush_in        (flush_in),
        .almost_full_out (almost_full_out),
        .overflow_out    (overflow_out),
        .range_valid_out (range_valid_out),
        .range_ready_in  (range_ready_in),
        .range_out       (range_out),
`ifdef AOC5_RANGE_SUM_EN
        .sum_out         (sum_out),
`endif
        .done_out        (done_out)
    );

    always #5 clock = ~clock;

    // Record every accepted output range.
    always @(negedge clock) begin
        if (!reset && range_valid_out && range_ready_in) got_q.push_back(range_out);
    end

    function automatic tuple_pair_t mk(input int s, input int e);
        tuple_pair_t p;
        p.start_val = VAL_WIDTH'(s);
        p.end_val   = VAL_WIDTH'(e);
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input tuple_pair_t [7:0] b);
        valid_in      = 1'b1;
        pairs_in_flat = b;
        step();
        valid_in      = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        valid_in = 1'b0;
        flush_in = 1'b0;
        step();
        reset    = 1'b0;
        got_q.delete();
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (!done_out && n < bound) begin
            step();
            n++;
        end
        check(tag, 32'(done_out), 32'd1);
    endtask

    task automatic check_results(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx, exp_q[i]);
        end
    endtask

    task automatic load_basic();
        bt    = '0;
        bt[0] = mk(1, 3);
        bt[1] = mk(2, 5);
        bt[2] = mk(7, 9);
        bt[3] = mk(10, 12);
        bt[4] = mk(20, 20);
    endtask

    task automatic load_stall_batch(input int b);
        bt    = '0;
        bt[0] = mk(16*b + 1, 16*b + 1);
        bt[1] = mk(16*b + 5, 16*b + 5);
        bt[2] = mk(16*b + 9, 16*b + 9);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_af"},    32'(almost_full_out), 32'd0);
        check({tag, "_ovf"},   32'(overflow_out),    32'd0);
        check({tag, "_valid"}, 32'(range_valid_out), 32'd0);
        check({tag, "_range"}, range_out,            32'd0);
        check({tag, "_done"},  32'(done_out),        32'd0);
`ifdef AOC5_RANGE_SUM_EN
        check({tag, "_sum"},   32'(sum_out),         32'd0);
`endif
    endtask

    task automatic basic_run(input string tag);
        range_ready_in = 1'b1;
        load_basic();
        send(bt);
        pulse_flush();
        wait_done({tag, "_done"}, 100);
        exp_q.delete();
        exp_q.push_back(mk(1, 5));
        exp_q.push_back(mk(7, 12));
        exp_q.push_back(mk(20, 20));
        check_results(tag);
    endtask

    initial begin
        int n;

        step();
        apply_reset();
        check_reset_outputs("reset");

        // Basic merge with padding and flush.
        basic_run("basic");
`ifdef AOC5_RANGE_SUM_EN
        check("basic_sum", 32'(sum_out), 32'd12);
`endif
        // Input after flush is ignored and does not flag overflow.
        bt    = '0;
        bt[0] = mk(100, 100);
        send(bt);
        pulse_flush();
        repeat (12) step();
        check("post_flush_ovf",   32'(overflow_out),   32'd0);
        check("post_flush_done",  32'(done_out),       32'd1);
        check("post_flush_count", 32'(got_q.size()),   32'd3);

        // Back-pressure: output held stable while not accepted.
        apply_reset();
        range_ready_in = 1'b0;
        load_basic();
        send(bt);
        pulse_flush();
        n = 0;
        while (!range_valid_out && n < 50) begin
            step();
            n++;
        end
        check("bp_first_valid", 32'(range_valid_out), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold_%0d", i), {range_valid_out ? range_out : 32'hffffffff}, mk(1, 5));
            step();
        end
        range_ready_in = 1'b1;
        wait_done("bp_done", 100);
        exp_q.delete();
        exp_q.push_back(mk(1, 5));
        exp_q.push_back(mk(7, 12));
        exp_q.push_back(mk(20, 20));
        check_results("bp");

        // Merge across a batch boundary.
        apply_reset();
        range_ready_in = 1'b1;
        bt    = '0;
        bt[0] = mk(10, 12);
        bt[1] = mk(30, 40);
        send(bt);
        bt    = '0;
        bt[0] = mk(35, 50);
        bt[1] = mk(51, 60);
        send(bt);
        pulse_flush();
        wait_done("xbatch_done", 100);
        exp_q.delete();
        exp_q.push_back(mk(10, 12));
        exp_q.push_back(mk(30, 60));
        check_results("xbatch");

        // Fill the FIFO while stalled: almost-full threshold and overflow.
        apply_reset();
        range_ready_in = 1'b0;
        for (int b = 0; b < 9; b++) begin
            check($sformatf("fill_af_%0d", b), 32'(almost_full_out), (b >= 2) ? 32'd1 : 32'd0);
            if (b == 8) check("fill_ovf_before", 32'(overflow_out), 32'd0);
            load_stall_batch(b);
            send(bt);
        end
        check("fill_ovf_after", 32'(overflow_out),    32'd1);
        check("fill_af_full",   32'(almost_full_out), 32'd1);
        check("fill_stalled",   range_out,            mk(1, 1));
        range_ready_in = 1'b1;
        pulse_flush();
        wait_done("fill_done", 600);
        check("fill_ovf_sticky", 32'(overflow_out), 32'd1);
        exp_q.delete();
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 3; k++) exp_q.push_back(mk(16*b + 1 + 4*k, 16*b + 1 + 4*k));
        end
        check_results("fill");

        // Reset mid-stream, then the basic run reproduces its output.
        apply_reset();
        range_ready_in = 1'b0;
        for (int b = 0; b < 9; b++) begin
            load_stall_batch(b);
            send(bt);
        end
        check("mid_ovf_pre",   32'(overflow_out),    32'd1);
        check("mid_valid_pre", 32'(range_valid_out), 32'd1);
        apply_reset();
        check_reset_outputs("mid_reset");
        basic_run("rerun");
`ifdef AOC5_RANGE_SUM_EN
        check("rerun_sum", 32'(sum_out), 32'd12);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
